// File: rtl/fpu_fpl_pkg.sv
// Shared constants and types for the low-precision FPU blocks (multiplier and divider).
// The operand format is the IEEE single layout. Only fraction bits [22:7] carry information.
`timescale 1ns/1ps
package fpu_fpl_pkg;

  localparam int unsigned FPL_BIAS   = 127;
  localparam int unsigned FPL_FRAC_W = 16;
  localparam int unsigned FPL_EXP_W  = 10;              // signed working exponent width
  localparam int unsigned FPL_MANT_W = FPL_FRAC_W + 1;  // mantissa with hidden one
  localparam int unsigned FPL_Q_W    = FPL_MANT_W + 1;  // quotient / remainder width
  localparam int unsigned FPL_ITER   = FPL_Q_W;         // one quotient bit per iteration
  localparam int unsigned FPL_CNT_W  = 5;

  localparam logic [30:0] FPL_INF = 31'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    PACK = 2'd2
  } fpl_state_e;

endpackage

// File: rtl/fpu_fpl_div.sv
// Low-precision single-precision divider. It uses an iterative restoring mantissa divide
// and has a fixed 19-cycle latency from the accept edge to the pack edge.
// Ports:
//   clk, reset_n   rising-edge clock, asynchronous active-low reset
//   enable         start request, sampled only while idle
//   srca, srcb     dividend / divisor (sign, exp[30:23], frac[22:7]; [6:0] ignored)
//   dst            quotient, held until the next result; dst[6:0] is always 0
//   busy           high from the accept edge until the pack edge
//   done           one-cycle pulse when dst is updated
`timescale 1ns/1ps
module fpu_fpl_div
  import fpu_fpl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  output logic [31:0] dst,
  output logic        busy,
  output logic        done
);

  fpl_state_e                  state;
  logic [FPL_CNT_W-1:0]        count;
  logic [FPL_Q_W-1:0]          r;
  logic [FPL_Q_W-1:0]          q;
  logic [FPL_MANT_W-1:0]       b_mant;
  logic [FPL_EXP_W-1:0]        exa;
  logic [FPL_EXP_W-1:0]        exb;
  logic                        sgnc;

  // Operand bits below the significant fraction are intentionally ignored
  logic unused_low_bits;
  assign unused_low_bits = &{1'b0, srca[6:0], srcb[6:0]};

  // Restoring divide step: compare, conditionally subtract, then shift the remainder
  logic [FPL_Q_W-1:0] b_ext_c;
  logic               q_bit_c;
  logic [FPL_Q_W-1:0] r_sel_c;
  logic [FPL_Q_W-1:0] r_next_c;

  always_comb begin
    b_ext_c  = {1'b0, b_mant};
    q_bit_c  = (r >= b_ext_c);
    r_sel_c  = q_bit_c ? (r - b_ext_c) : r;
    // The remainder is below B < 2^17 here, so dropping the MSB on the shift loses nothing
    r_next_c = {r_sel_c[FPL_Q_W-2:0], 1'b0};
  end

  // Normalize the quotient and select the packed result, including the special cases
  logic [FPL_EXP_W-1:0]  exc_c;
  logic [FPL_FRAC_W-1:0] frac_c;
  logic [31:0]           result_c;

  always_comb begin
    if (q[FPL_Q_W-1]) begin
      frac_c = q[FPL_Q_W-2:1];
      exc_c  = exa - exb + FPL_EXP_W'(FPL_BIAS);
    end else begin
      frac_c = q[FPL_FRAC_W-1:0];
      exc_c  = exa - exb + FPL_EXP_W'(FPL_BIAS - 1);
    end

    if (exb == '0) begin
      result_c = {sgnc, FPL_INF};                       // divide by zero
    end else if (exa == '0) begin
      result_c = 32'h0;                                 // zero / denormal dividend
    end else if (exa == FPL_EXP_W'(255)) begin
      result_c = {sgnc, FPL_INF};
    end else if (exb == FPL_EXP_W'(255)) begin
      result_c = 32'h0;
    end else if (exc_c[FPL_EXP_W-1]) begin
      result_c = 32'h0;                                 // underflow
    end else if (exc_c[FPL_EXP_W-2]) begin
      result_c = {sgnc, FPL_INF};                       // overflow
    end else begin
      result_c = {sgnc, exc_c[7:0], frac_c, 7'b0};
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      count  <= '0;
      r      <= '0;
      q      <= '0;
      b_mant <= '0;
      exa    <= '0;
      exb    <= '0;
      sgnc   <= 1'b0;
      dst    <= 32'h0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (enable) begin
            sgnc   <= srca[31] ^ srcb[31];
            exa    <= {2'b00, srca[30:23]};
            exb    <= {2'b00, srcb[30:23]};
            r      <= {2'b01, srca[22:7]};
            b_mant <= {1'b1, srcb[22:7]};
            q      <= '0;
            count  <= FPL_CNT_W'(FPL_ITER);
            busy   <= 1'b1;
            state  <= DIV;
          end
        end
        DIV: begin
          r     <= r_next_c;
          q     <= {q[FPL_Q_W-2:0], q_bit_c};
          count <= count - FPL_CNT_W'(1);
          if (count == FPL_CNT_W'(1)) begin
            state <= PACK;
          end
        end
        PACK: begin
          dst   <= result_c;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_fpl_div.sv
// Self-checking bench for fpu_fpl_div. It applies a directed vector table, randomized
// operands against a behavioural model, handshake corner cases and a reset during a division.
`timescale 1ns/1ps
module tb_fpu_fpl_div;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [31:0] dst;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  fpu_fpl_div dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .srca    (srca),
    .srcb    (srcb),
    .dst     (dst),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Behavioural reference: real-valued quotient of the 16-bit mantissas, truncated
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic        sg;
    int          ea, eb, e;
    longint      ma, mb, qv, fr;
    logic [7:0]  e8;
    logic [15:0] f16;
    logic [30:0] inf;
    inf = 31'h7F80_0000;
    sg = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (eb == 0)   return {sg, inf};
    if (ea == 0)   return 32'h0;
    if (ea == 255) return {sg, inf};
    if (eb == 255) return 32'h0;
    ma = 65536 + longint'(a[22:7]);
    mb = 65536 + longint'(b[22:7]);
    qv = (ma * 131072) / mb;
    if (qv >= 131072) begin
      e  = ea - eb + 127;
      fr = (qv / 2) % 65536;
    end else begin
      e  = ea - eb + 126;
      fr = qv % 65536;
    end
    if (e < 0)   return 32'h0;
    if (e > 255) return {sg, inf};
    e8  = 8'(e);
    f16 = 16'(fr);
    return {sg, e8, f16, 7'b0};
  endfunction

  // Entered at a negedge: present operands, let the next posedge accept, return at the next negedge
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    srca   = a;
    srcb   = b;
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
  endtask

  // Waits (bounded) for done; lat counts cycles after accept, nb counts cycles with busy high
  task automatic wait_done(output int lat, output int nb);
    lat = 0;
    nb  = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) nb++;
    end
    if (!done) begin
      errors++;
      $display("FAIL timeout: done not seen after %0d cycles, expected within 19", lat);
    end
  endtask

  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] req, input bit timing);
    int lat, nb;
    start(a, b);
    wait_done(lat, nb);
    chk(name, dst, req);
    if (timing) begin
      chk({name, "_lat"}, 32'(lat), 32'd19);
      chk({name, "_busy"}, 32'(nb), 32'd19);
    end
  endtask

  vec_t vecs[$];

  initial begin
    int lat, nb, ndone, i;
    logic [31:0] first_dst;
    logic [31:0] ra, rb;

    reset_n = 1'b0;
    enable  = 1'b0;
    srca    = 32'h0;
    srcb    = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_dst",  dst, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    vecs.push_back('{32'h40C00000, 32'h40000000, 32'h40400000});
    vecs.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAA80});
    vecs.push_back('{32'hBF800000, 32'h40400000, 32'hBEAAAA80});
    vecs.push_back('{32'h3F800000, 32'h00000000, 32'h7F800000});
    vecs.push_back('{32'hBF800000, 32'h00000000, 32'hFF800000});
    vecs.push_back('{32'h00000000, 32'h40000000, 32'h00000000});
    vecs.push_back('{32'h7E800000, 32'h00800000, 32'h7F800000});
    vecs.push_back('{32'h00800000, 32'h7E800000, 32'h00000000});
    vecs.push_back('{32'h7F800000, 32'hC0000000, 32'hFF800000});
    vecs.push_back('{32'h40000000, 32'h7F800000, 32'h00000000});
    vecs.push_back('{32'h40C0007F, 32'h4000007F, 32'h40400000});
    foreach (vecs[k]) begin
      run_div($sformatf("vec%0d", k), vecs[k].a, vecs[k].b, vecs[k].exp, 1'b1);
    end

    // Randomized operands with occasional special exponents
    for (int k = 0; k < 40; k++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: ra[30:23] = 8'd0;
        1: ra[30:23] = 8'd255;
        2: rb[30:23] = 8'd0;
        3: rb[30:23] = 8'd255;
        default: begin
          ra[30:23] = 8'($urandom_range(1, 254));
          rb[30:23] = 8'($urandom_range(1, 254));
        end
      endcase
      run_div($sformatf("rnd%0d_%h_%h", k, ra, rb), ra, rb, ref_div(ra, rb), 1'b0);
    end

    // enable pulsed while busy is ignored; operands are not re-latched
    start(32'h40C00000, 32'h40000000);
    ndone = 0;
    first_dst = 32'h0;
    lat = 0;
    for (i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          first_dst = dst;
          lat = i;
        end
      end
      enable = (i == 5 || i == 10);
      srca   = 32'h3F800000;
      srcb   = 32'h40400000;
    end
    enable = 1'b0;
    chk("busy_en_ndone", 32'(ndone), 32'd1);
    chk("busy_en_dst", first_dst, 32'h40400000);
    chk("busy_en_lat", 32'(lat), 32'd19);

    // Back-to-back: enable in the done cycle is accepted
    start(32'h40C00000, 32'h40000000);
    wait_done(lat, nb);
    chk("b2b_first", dst, 32'h40400000);
    start(32'h3F800000, 32'h40400000);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done_low", 32'(done), 32'd0);
    wait_done(lat, nb);
    chk("b2b_second", dst, 32'h3EAAAA80);
    chk("b2b_lat", 32'(lat), 32'd19);

    // Reset during iteration 9 discards the division
    start(32'h40C00000, 32'h40000000);
    repeat (9) @(negedge clk);
    chk("mid_busy_pre", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_dst",  dst, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("mid_rst_nodone", 32'(ndone), 32'd0);
    run_div("post_rst", 32'h3F800000, 32'h40400000, 32'h3EAAAA80, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
